// File: rtl/fpga_io_pkg.sv
// Shared types for the FPGA I/O display path: one displayed store entry and
// the scheduler FSM state.
package fpga_io_pkg;

    localparam int DWELL_1S_50MHZ = 50_000_000;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } disp_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } disp_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered occupancy count and a combinational head.
// Full/empty come from the count so the wrapping pointers never alias.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    // Handshake: pop is honoured only when not empty; push is honoured when
    // not full, or when a real pop frees a slot at the same edge.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/store_display_sched.sv
// Buffers core store events and shows each one on the 16 LEDs for a fixed
// dwell time, in arrival order, with sticky overflow reporting.
module store_display_sched
    import fpga_io_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int DWELL_CYCLES = DWELL_1S_50MHZ
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     MemWriteM,
    input  logic [31:0]              ALUResultM,
    input  logic [31:0]              WriteDataM,
    input  logic                     hold,
    input  logic                     clr_ovf,
    output logic [15:0]              LED,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);

    // A one-cycle dwell still needs a one-bit counter.
    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    disp_state_t      state;
    logic [CNT_W-1:0] dwell_cnt;
    disp_entry_t      wr_entry;
    disp_entry_t      head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop_req;
    logic             drop;
    logic             unused_hi;

    assign wr_entry  = '{addr: ALUResultM[7:0], data: WriteDataM[7:0]};
    assign unused_hi = ^{ALUResultM[31:8], WriteDataM[31:8]};

    sync_fifo #(
        .WIDTH ($bits(disp_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (MemWriteM),
        .pop   (pop_req),
        .din   (wr_entry),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // IDLE loads regardless of hold; SHOW only advances when not held.
    assign pop_req = ~fifo_empty & ((state == IDLE) | (~hold & (dwell_cnt == '0)));
    assign drop    = MemWriteM & fifo_full & ~pop_req;
    assign busy    = (state == SHOW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dwell_cnt <= '0;
            LED       <= '0;
        end else if (pop_req) begin
            state     <= SHOW;
            dwell_cnt <= DWELL_LAST;
            LED       <= head;
        end else if (state == SHOW && !hold) begin
            if (dwell_cnt != '0) begin
                dwell_cnt <= dwell_cnt - 1'b1;
            end else begin
                state <= IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_store_display_sched.sv
// Bench for store_display_sched: directed scenarios plus random traffic, all
// checked every cycle against a queue-based model of the display schedule.
module tb_store_display_sched;

    localparam int DEPTH = 8;
    localparam int DWELL = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MemWriteM = 1'b0;
    logic [31:0] ALUResultM = '0;
    logic [31:0] WriteDataM = '0;
    logic        hold = 1'b0;
    logic        clr_ovf = 1'b0;
    logic [15:0] LED;
    logic        busy;
    logic [3:0]  fifo_count;
    logic        overflow;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // Model state: pending entries, shown entry, cycles left on it.
    logic [15:0] exp_q[$];
    logic [15:0] m_led = '0;
    bit          m_busy = 1'b0;
    int          m_left = 0;
    bit          m_ovf = 1'b0;
    bit          m_will;
    bit          m_acc;

    store_display_sched #(.DEPTH(DEPTH), .DWELL_CYCLES(DWELL)) dut (
        .clk        (clk),
        .rst        (rst),
        .MemWriteM  (MemWriteM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .hold       (hold),
        .clr_ovf    (clr_ovf),
        .LED        (LED),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_will_pop(input logic h);
        return (exp_q.size() > 0) && (!m_busy || (!h && m_left == 1));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            m_led  = '0;
            m_busy = 1'b0;
            m_left = 0;
            m_ovf  = 1'b0;
        end else begin
            m_will = model_will_pop(hold);
            m_acc  = MemWriteM && (exp_q.size() < DEPTH || m_will);
            if (m_will) begin
                m_led  = exp_q.pop_front();
                m_busy = 1'b1;
                m_left = DWELL;
            end else if (m_busy && !hold) begin
                if (m_left > 1) m_left--;
                else m_busy = 1'b0;
            end
            if (MemWriteM && m_acc) exp_q.push_back({ALUResultM[7:0], WriteDataM[7:0]});
            if (MemWriteM && !m_acc) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("led", 32'(LED), 32'(m_led));
            check("busy", 32'(busy), 32'(m_busy));
            check("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
            check("overflow", 32'(overflow), 32'(m_ovf));
        end
    end

    task automatic set_store(input logic [7:0] a, input logic [7:0] d);
        MemWriteM  = 1'b1;
        ALUResultM = {$urandom_range(0, 32'hffffff), a};
        WriteDataM = {$urandom_range(0, 32'hffffff), d};
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((busy || fifo_count != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(n < budget), 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_led", 32'(LED), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_count", 32'(fifo_count), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        chk_en = 1'b1;

        // Single store: visible after the second edge, busy for DWELL cycles.
        @(negedge clk);
        set_store(8'h64, 8'h19);
        @(negedge clk);
        MemWriteM = 1'b0;
        check("single_queued", 32'(fifo_count), 32'd1);
        for (int i = 1; i <= DWELL; i++) begin
            @(negedge clk);
            check("single_led", 32'(LED), 32'h6419);
            check("single_busy", 32'(busy), 32'd1);
        end
        @(negedge clk);
        check("single_idle", 32'(busy), 32'd0);
        check("single_led_hold", 32'(LED), 32'h6419);
        check("single_count", 32'(fifo_count), 32'd0);

        // Burst of three: back-to-back display, no gap cycles.
        set_store(8'h01, 8'hA1);
        @(negedge clk);
        set_store(8'h02, 8'hA2);
        @(negedge clk);
        check("burst_led1", 32'(LED), 32'h01A1);
        set_store(8'h03, 8'hA3);
        @(negedge clk);
        MemWriteM = 1'b0;
        check("burst_peak", 32'(fifo_count), 32'd2);
        for (int i = 3; i <= 3 * DWELL; i++) begin
            @(negedge clk);
            check("burst_seq", 32'(LED), (i <= DWELL) ? 32'h01A1 : (i <= 2 * DWELL) ? 32'h02A2 : 32'h03A3);
        end
        wait_drain(50);

        // Hold mid-dwell freezes the display while stores keep queueing.
        @(negedge clk);
        set_store(8'h55, 8'h66);
        @(negedge clk);
        MemWriteM = 1'b0;
        @(negedge clk);
        hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i < 3) set_store(8'(8'h70 + i), 8'(i));
            else MemWriteM = 1'b0;
            @(negedge clk);
        end
        check("hold_led", 32'(LED), 32'h5566);
        check("hold_count", 32'(fifo_count), 32'd3);
        hold = 1'b0;
        wait_drain(100);

        // Overflow: with the display held, ten stores leave 8 queued, one dropped.
        @(negedge clk);
        hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_store(8'(8'h10 + i), 8'(8'hC0 + i));
            @(negedge clk);
        end
        MemWriteM = 1'b0;
        @(negedge clk);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_count", 32'(fifo_count), 32'd8);
        check("ovf_led", 32'(LED), 32'h10C0);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);
        set_store(8'hEE, 8'hEE);
        clr_ovf = 1'b1;
        @(negedge clk);
        MemWriteM = 1'b0;
        clr_ovf = 1'b0;
        check("ovf_set_wins", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;

        // Full FIFO: push only on the cycles where the dwell expires.
        hold = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (model_will_pop(hold)) begin
                set_store(8'(8'hB0 + i), 8'(i));
                @(negedge clk);
                MemWriteM = 1'b0;
                check("fullpop_count", 32'(fifo_count), 32'd8);
                check("fullpop_ovf", 32'(overflow), 32'd0);
            end else begin
                @(negedge clk);
            end
        end
        wait_drain(200);

        // Random traffic with varying store density.
        for (int blk = 0; blk < 15; blk++) begin
            int rate = $urandom_range(5, 95);
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if ($urandom_range(0, 99) < rate) set_store(8'($urandom), 8'($urandom));
                else MemWriteM = 1'b0;
                hold    = ($urandom_range(0, 99) < 6);
                clr_ovf = ($urandom_range(0, 99) < 3);
            end
        end
        @(negedge clk);
        MemWriteM = 1'b0;
        hold = 1'b0;
        clr_ovf = 1'b0;
        wait_drain(200);

        // Asynchronous reset between edges while showing an entry.
        set_store(8'h42, 8'h24);
        @(negedge clk);
        set_store(8'h43, 8'h34);
        @(negedge clk);
        MemWriteM = 1'b0;
        @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_led", 32'(LED), 32'h0);
        check("arst_count", 32'(fifo_count), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_ovf", 32'(overflow), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst_idle", 32'(busy), 32'd0);
        check("post_rst_led", 32'(LED), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/store_display_sched.md
Name: store_display_sched

Overview:
- Schedules core store events onto the 16 Basys3 LEDs. Sits between the pipelined core's memory-stage outputs (MemWriteM, ALUResultM, WriteDataM) and the LED pins.
- Every store is buffered in a small FIFO. Each buffered store is shown for a fixed dwell time, so bursts of stores are all readable instead of only the last one.
- Shares the single LED resource among stores in arrival order. Reports occupancy and overflow.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- DWELL_CYCLES, 50_000_000, clk cycles each entry stays on the LEDs (1 s at 50 MHz); minimum 1.
- CNT_W, $clog2(DWELL_CYCLES), dwell counter width; derived, do not override.

Ports:
- clk  in  1  system clock (50 MHz core clock domain).
- rst  in  1  asynchronous, active-high reset.
- MemWriteM  in  1  store strobe from core memory stage; one store per high cycle.
- ALUResultM  in  32  store address; bits [7:0] are captured.
- WriteDataM  in  32  store data; bits [7:0] are captured.
- hold  in  1  freezes the current display (dwell counter stalls); FIFO still accepts stores.
- clr_ovf  in  1  clears the overflow flag.
- LED  out  16  {disp_addr[7:0], disp_data[7:0]} of the entry currently shown.
- busy  out  1  high while in SHOW state.
- fifo_count  out  $clog2(DEPTH)+1  number of entries currently buffered.
- overflow  out  1  sticky; set when a store is dropped because the FIFO is full.

Behaviour:
- Reset (async, any time, including mid-dwell): LED=0, busy=0, fifo_count=0, overflow=0, FSM=IDLE, dwell counter=0, FIFO pointers=0. All in-flight entries are discarded.
- Push: at a clk edge with MemWriteM=1, write {ALUResultM[7:0], WriteDataM[7:0]} into the FIFO if it is not full, or if a pop occurs in the same cycle.
- Full and no pop: drop the entry and set overflow at that edge.
- overflow: clr_ovf=1 clears it. If a drop and clr_ovf occur in the same cycle, set wins.
- Pop: the FIFO head is read combinationally. Popping registers the head into the display register (LED) at the same edge.
- Simultaneous push and pop: both take effect. fifo_count is unchanged. Pushing into an empty FIFO while a pop is requested is not a pop; the FSM sees the entry one cycle later.
- FSM states: IDLE, SHOW.
- IDLE, FIFO empty: stay in IDLE. LED keeps the last displayed entry (0 after reset).
- IDLE, FIFO not empty: pop, load LED, dwell counter=DWELL_CYCLES-1, go to SHOW.
- SHOW, hold=1: counter and state frozen.
- SHOW, hold=0, counter>0: counter decrements.
- SHOW, counter=0, hold=0, FIFO not empty: pop, reload LED, counter=DWELL_CYCLES-1, stay in SHOW (back-to-back, no gap cycle).
- SHOW, counter=0, hold=0, FIFO empty: go to IDLE. LED holds.
- Latency: a store sampled at edge k into an empty FIFO with the FSM in IDLE appears on LED after edge k+1.
- Dwell: with hold low, each entry is on the LED for exactly DWELL_CYCLES cycles before the next one loads. DWELL_CYCLES=1 gives one entry per cycle.
- Wrap-around: FIFO pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty are derived from fifo_count, never from pointer equality alone.
- busy = (state==SHOW). All outputs are registered except busy and fifo_count, which decode from registered state.

Decomposition:
- Shared package fpga_io_pkg holds:
  - disp_entry_t: packed struct {logic [7:0] addr; logic [7:0] data;}.
  - disp_state_t: enum {IDLE, SHOW}.
  - localparam DWELL_1S_50MHZ = 50_000_000.
- One sub-module, sync_fifo (parameterised WIDTH, DEPTH; ports push, pop, din, dout, full, empty, count), uses the same clk/rst conventions.
- The FSM, dwell counter and overflow logic live in store_display_sched.

Test Plan:
- Single store: DWELL_CYCLES=4; MemWriteM=1 for one cycle with ALUResultM=32'h64, WriteDataM=32'h19 → LED=16'h6419 after the next edge, busy high for 4 cycles, then IDLE with LED still 16'h6419, fifo_count=0.
- Burst: DWELL_CYCLES=4; 3 consecutive stores (addr 01/02/03, data A1/A2/A3) → LED shows 0x01A1, 0x02A2, 0x03A3 for exactly 4 cycles each, with no gap; fifo_count peaks at 2.
- Overflow and wrap: DEPTH=8, DWELL_CYCLES=100; 10 stores back-to-back → first displayed, 8 buffered, 10th dropped, overflow=1. Drain all entries in order, with pointers wrapping. clr_ovf pulse → overflow=0. Drop and clr_ovf in the same cycle → overflow stays 1.
- Hold: assert hold for 10 cycles mid-dwell → LED and counter frozen, stores still counted in fifo_count. Release → remaining dwell completes.
- Full with simultaneous pop: fill the FIFO, then push on the exact cycle the dwell expires → push accepted, overflow stays 0, fifo_count unchanged.
- Async reset mid-SHOW, asserted between clock edges → LED=0, fifo_count=0, busy=0 immediately. After release, an empty FIFO stays IDLE.
